// File: rtl/l1_to_l2_request.sv
// L1-side miss requester: issues one request to L2, retries on tag mismatch or timeout,
// presents the returned line on the fill port or pulses err_valid once retries run out.
module l1_to_l2_request #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              req_to_l2,
  output logic [ADDR_W-1:0] addr,
  input  logic              ack_to_l1,
  input  logic [ADDR_W-1:0] addr_tag,
  input  logic [DATA_W-1:0] data,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  input  logic              fill_ready,
  output logic              err_valid,
  output logic              busy
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RT_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    GAP  = 3'd2,
    FILL = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [RT_W-1:0] retry_cnt;
  logic            tag_hit;

  assign miss_ready = (state == IDLE);
  assign tag_hit    = (addr_tag == addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_to_l2  <= 1'b0;
      addr       <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      err_valid  <= 1'b0;
      busy       <= 1'b0;
      to_cnt     <= '0;
      retry_cnt  <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            addr      <= miss_addr;
            retry_cnt <= '0;
            to_cnt    <= '0;
            req_to_l2 <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
          end
          // A matching ack on the timeout cycle still counts as a response.
          if (ack_to_l1 && tag_hit) begin
            fill_data  <= data;
            fill_addr  <= addr;
            fill_valid <= 1'b1;
            req_to_l2  <= 1'b0;
            state      <= FILL;
          end else if (ack_to_l1 || (to_cnt == TO_LAST)) begin
            req_to_l2 <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= GAP;
            end else begin
              err_valid <= 1'b1;
              state     <= ERR;
            end
          end
        end
        GAP: begin
          to_cnt    <= '0;
          req_to_l2 <= 1'b1;
          state     <= REQ;
        end
        FILL: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          req_to_l2  <= 1'b0;
          fill_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_to_l2_request.sv
// Bench for l1_to_l2_request: directed scenarios plus randomized transactions,
// each checked against a per-attempt outcome model of the request/retry protocol.
module tb_l1_to_l2_request;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 256;
  localparam int unsigned TO = 8;
  localparam int unsigned MR = 3;
  localparam int unsigned NA = MR + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miss_valid = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          miss_ready;
  logic          req_to_l2;
  logic [AW-1:0] addr;
  logic          ack_to_l1 = 1'b0;
  logic [AW-1:0] addr_tag = '0;
  logic [DW-1:0] data = '0;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          fill_ready = 1'b0;
  logic          err_valid;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Per-attempt L2 behaviour: 0 = silent, 1 = ack with wrong tag, 2 = ack with right tag.
  int unsigned plan_kind [NA];
  int unsigned plan_dly  [NA];

  l1_to_l2_request #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .req_to_l2(req_to_l2), .addr(addr),
    .ack_to_l1(ack_to_l1), .addr_tag(addr_tag), .data(data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_ready(fill_ready), .err_valid(err_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_miss_ready"}, DW'(miss_ready), DW'(1));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_req"}, DW'(req_to_l2), DW'(0));
    chk({tag, "_fill_valid"}, DW'(fill_valid), DW'(0));
    chk({tag, "_err"}, DW'(err_valid), DW'(0));
  endtask

  // Drives one miss through the L2 behaviour in plan_*; expected outcome comes from the
  // protocol rules: the first attempt with a correct-tag ack fills, no such attempt -> error.
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] line, input int unsigned hold,
                         input bit stray);
    int win;
    int unsigned last;
    int unsigned len;
    int unsigned req_cycles;
    int unsigned exp_req_cycles;
    win = -1;
    for (int k = 0; k < int'(NA); k++) if (win < 0 && plan_kind[k] == 2) win = k;
    last = (win < 0) ? MR : int'(win);
    exp_req_cycles = 0;
    for (int unsigned k = 0; k <= last; k++)
      exp_req_cycles += (plan_kind[k] != 0) ? plan_dly[k] + 1 : TO;

    chk_idle("pre");
    miss_valid = 1'b1;
    miss_addr  = a;
    step();
    miss_valid = 1'b0;
    miss_addr  = AW'($urandom);
    req_cycles = 0;
    for (int unsigned k = 0; k <= last; k++) begin
      len = (plan_kind[k] != 0) ? plan_dly[k] + 1 : TO;
      for (int unsigned c = 0; c < len; c++) begin
        req_cycles += int'(req_to_l2);
        chk("req_addr", DW'(addr), DW'(a));
        chk("req_no_fill", DW'(fill_valid), DW'(0));
        chk("req_no_err", DW'(err_valid), DW'(0));
        chk("req_busy", DW'({busy, miss_ready}), DW'(2'b10));
        if (c == len - 1 && plan_kind[k] != 0) begin
          ack_to_l1 = 1'b1;
          addr_tag  = (plan_kind[k] == 2) ? a : a ^ AW'(1 + $urandom_range(0, 65534));
          data      = (plan_kind[k] == 2) ? line : ~line;
        end else begin
          ack_to_l1 = 1'b0;
          addr_tag  = AW'($urandom);
          data      = rand_line();
        end
        step();
      end
      ack_to_l1 = 1'b0;
      if (k < last) begin
        chk("gap_req_low", DW'(req_to_l2), DW'(0));
        chk("gap_busy", DW'(busy), DW'(1));
        chk("gap_addr", DW'(addr), DW'(a));
        step();
      end
    end
    chk("req_cycle_count", DW'(req_cycles), DW'(exp_req_cycles));

    if (win >= 0) begin
      for (int unsigned h = 0; h <= hold; h++) begin
        chk("fill_valid", DW'(fill_valid), DW'(1));
        chk("fill_addr", DW'(fill_addr), DW'(a));
        chk("fill_data", fill_data, line);
        chk("fill_req_low", DW'(req_to_l2), DW'(0));
        chk("fill_no_err", DW'(err_valid), DW'(0));
        chk("fill_not_ready", DW'(miss_ready), DW'(0));
        fill_ready = (h == hold);
        ack_to_l1  = stray && ($urandom_range(0, 1) == 1);
        addr_tag   = a;
        data       = rand_line();
        step();
      end
      fill_ready = 1'b0;
      ack_to_l1  = 1'b0;
      chk_idle("post_fill");
    end else begin
      chk("err_pulse", DW'(err_valid), DW'(1));
      chk("err_addr", DW'(addr), DW'(a));
      chk("err_no_fill", DW'(fill_valid), DW'(0));
      chk("err_req_low", DW'(req_to_l2), DW'(0));
      step();
      chk_idle("post_err");
    end
  endtask

  initial begin
    logic [DW-1:0] beef;
    beef = {8{32'hDEADBEEF}};

    #1;
    chk_idle("reset");
    chk("reset_addr", DW'(addr), DW'(0));
    chk("reset_fill_addr", DW'(fill_addr), DW'(0));
    chk("reset_fill_data", fill_data, DW'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Hit path: ack on 4th request cycle, fill_ready two cycles after fill_valid.
    plan_kind = '{2, 0, 0, 0};
    plan_dly  = '{3, 0, 0, 0};
    run_txn(16'h1A40, beef, 2, 1'b0);

    // Tag mismatch, then correct tag.
    plan_kind = '{1, 2, 0, 0};
    plan_dly  = '{2, 4, 0, 0};
    run_txn(16'h1A40, beef, 0, 1'b0);

    // Two timeouts, ack on third attempt; ack on timeout cycle wins.
    plan_kind = '{0, 0, 2, 0};
    plan_dly  = '{0, 0, TO - 1, 0};
    run_txn(16'h1A40, ~beef, 1, 1'b0);

    // Exhaustion: L2 never answers.
    plan_kind = '{0, 0, 0, 0};
    plan_dly  = '{0, 0, 0, 0};
    run_txn(16'h1A40, beef, 0, 1'b0);

    // Back-pressure with stray acks during FILL.
    plan_kind = '{2, 0, 0, 0};
    plan_dly  = '{0, 0, 0, 0};
    run_txn(16'h2B7C, rand_line(), 20, 1'b1);

    // Stray acks in IDLE must not start anything.
    for (int i = 0; i < 3; i++) begin
      ack_to_l1 = 1'b1;
      addr_tag  = addr;
      step();
      ack_to_l1 = 1'b0;
      chk_idle("stray_idle");
    end

    // Async reset mid-request, then a clean transaction.
    miss_valid = 1'b1;
    miss_addr  = 16'h3C3C;
    step();
    miss_valid = 1'b0;
    step();
    step();
    chk("pre_rst_req", DW'(req_to_l2), DW'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", DW'(req_to_l2), DW'(0));
    chk("async_rst_busy", DW'(busy), DW'(0));
    chk("async_rst_ready", DW'(miss_ready), DW'(1));
    chk("async_rst_addr", DW'(addr), DW'(0));
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle("after_rst");
    plan_kind = '{1, 2, 0, 0};
    plan_dly  = '{5, 1, 0, 0};
    run_txn(16'h00FF, rand_line(), 1, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < int'(NA); k++) begin
        plan_kind[k] = $urandom_range(0, 2);
        plan_dly[k]  = $urandom_range(0, TO - 1);
      end
      run_txn(AW'($urandom), rand_line(), $urandom_range(0, 4), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_to_l2_request.md
Name: l1_to_l2_request

Overview:
- L1-side miss requester. It is the initiator end of the L1/L2 interface whose responder is the L2 lookup/return block.
- Accepts one L1 miss at a time and drives req_to_l2/addr toward L2.
- Waits for ack_to_l1 with a matching addr_tag, then presents the returned 256-bit line to the L1 fill port.
- Recovers from tag mismatch and non-response by timeout and retry. Reports a hard error once retries are exhausted.

Parameters:
ADDR_W, 16, width of miss/request address and returned tag
DATA_W, 256, width of returned cache line
TIMEOUT, 64, cycles to wait for ack_to_l1 before abandoning an attempt (min 2)
MAX_RETRY, 3, retries after the first attempt; total attempts = MAX_RETRY+1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
miss_valid  input  1  L1 presents a miss
miss_addr  input  ADDR_W  miss address
miss_ready  output  1  block idle, can accept a miss
req_to_l2  output  1  request to L2
addr  output  ADDR_W  request address to L2
ack_to_l1  input  1  L2 response valid
addr_tag  input  ADDR_W  tag returned by L2
data  input  DATA_W  line returned by L2
fill_valid  output  1  fill line available to L1
fill_addr  output  ADDR_W  fill address
fill_data  output  DATA_W  fill line
fill_ready  input  1  L1 accepts fill
err_valid  output  1  one-cycle pulse: miss abandoned
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - req_to_l2, fill_valid, err_valid, busy = 0; miss_ready = 1.
  - addr, fill_addr, fill_data, retry count and timeout counter = 0.
  - Reset mid-transaction discards the miss; no fill and no err is produced.
- States: IDLE, REQ, GAP, FILL, ERR. All outputs are registered except miss_ready (= state==IDLE).
- IDLE:
  - miss_valid & miss_ready accepts the miss: latch miss_addr into addr, clear retry and timeout counters, go to REQ.
  - req_to_l2 is high starting the cycle after acceptance.
- REQ:
  - req_to_l2 = 1; addr held stable.
  - Timeout counter increments every cycle in REQ.
  - ack_to_l1 is sampled only in REQ. An ack in any other state is ignored.
- REQ, on ack_to_l1 = 1:
  - If addr_tag == addr: capture data into fill_data and addr into fill_addr, go to FILL. req_to_l2 drops and fill_valid rises on the next edge (1-cycle ack-to-fill latency).
  - If addr_tag != addr: treat as a failed attempt.
- REQ, with no ack and counter == TIMEOUT-1: treat as a failed attempt.
- An ack in the same cycle as the timeout wins; the attempt counts as a response.
- Failed attempt:
  - If retry count < MAX_RETRY: increment the retry count, go to GAP.
  - Otherwise: go to ERR.
- GAP:
  - req_to_l2 = 0 for exactly one cycle, which re-arms the L2 handshake.
  - Clear the timeout counter, return to REQ. addr is unchanged.
- FILL:
  - fill_valid held high; fill_addr and fill_data stable until fill_ready.
  - On fill_valid & fill_ready: next cycle fill_valid = 0, state IDLE, miss_ready = 1.
  - No new miss is accepted in the same cycle as the fill handshake.
- ERR:
  - err_valid = 1 for one cycle, with addr still holding the failed address.
  - Then go to IDLE. No fill is issued.
- Counters:
  - Timeout counter width is clog2(TIMEOUT); it saturates and never wraps.
  - Retry counter width is clog2(MAX_RETRY+1).
  - Tag compare is a full ADDR_W equality.
- Invariants:
  - req_to_l2 is never high while fill_valid is high.
  - At most one outstanding request.
  - miss_valid outside IDLE is ignored; L1 must hold it until miss_ready.

Test Plan:
1. Hit path: miss_addr=16'h1A40 accepted at cycle 0; L2 acks at cycle 4 with addr_tag=16'h1A40, data=256'hDEAD..BEEF -> req_to_l2 high cycles 1-4; fill_valid high cycle 5 with fill_addr=16'h1A40 and that data; fill_ready at cycle 7 -> miss_ready=1 at cycle 8.
2. Tag mismatch then good: first ack carries addr_tag=16'h0001 for addr=16'h1A40 -> req_to_l2 low exactly 1 cycle, then re-asserted; second ack with 16'h1A40 -> fill with correct data; err_valid never pulses.
3. Timeout retry: TIMEOUT=8, no ack -> req_to_l2 high 8 cycles, low 1, high again; ack on the 3rd attempt -> normal fill.
4. Exhaustion: MAX_RETRY=3, no ack ever -> 4 attempts of 8 cycles each; err_valid single pulse with addr=16'h1A40; then miss_ready=1; fill_valid never high.
5. Back-pressure and stray acks: fill_ready held low 20 cycles -> fill_valid/fill_data stable throughout and req_to_l2=0; ack_to_l1 pulses during FILL and IDLE -> no state change.
6. Async reset: rst low mid-REQ (between edges) -> req_to_l2=0, busy=0, miss_ready=1 immediately; after release, new miss 16'h00FF completes normally.
